// File: rtl/sap_controller_sequencer.sv
// Controller-sequencer for the 8-bit SAP datapath.
// A one-hot ring counter (T1..T6) steps through fetch and execute. The control
// word is a combinational decode of ring state, halt flag, opcode and clr.
module sap_controller_sequencer (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] opcode,
  output logic       cp,
  output logic       ep,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb,
  output logic       lo,
  output logic       hlt,
  output logic [5:0] t_state
);

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  logic [5:0] ring_q, ring_d;
  logic       halted_q, halted_d;
  logic       ring_legal;
  logic       halt_now;

  // Exactly one bit set; anything else is treated as an upset.
  assign ring_legal = (ring_q != 6'b0) && ((ring_q & (ring_q - 6'd1)) == 6'b0);
  assign halt_now   = !clr && !halted_q && (ring_q == T4) && (opcode == OP_HLT);

  // Next-state: clr wins, halt freezes the ring at T4, upsets recover to T1.
  always_comb begin
    ring_d   = ring_q;
    halted_d = halted_q;
    if (clr) begin
      ring_d   = T1;
      halted_d = 1'b0;
    end else if (halted_q) begin
      ring_d   = ring_q;
    end else if (!ring_legal) begin
      ring_d   = T1;
    end else if (halt_now) begin
      halted_d = 1'b1;
    end else begin
      ring_d   = {ring_q[4:0], ring_q[5]};
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (clr) begin
      ring_q   <= T1;
      halted_q <= 1'b0;
    end else begin
      ring_q   <= ring_d;
      halted_q <= halted_d;
    end
  end

  // Control word decode; bus stays quiet during clr, halt and illegal ring states.
  always_comb begin
    cp      = 1'b0;
    ep      = 1'b0;
    lm      = 1'b0;
    ce      = 1'b0;
    li      = 1'b0;
    ei      = 1'b0;
    la      = 1'b0;
    ea      = 1'b0;
    su      = 1'b0;
    eu      = 1'b0;
    lb      = 1'b0;
    lo      = 1'b0;
    hlt     = !clr && halted_q;
    t_state = halted_q ? 6'b0 : ring_q;
    if (!clr && !halted_q && ring_legal) begin
      // su held across the whole SUB execute so the ALU result settles before eu.
      su = (opcode == OP_SUB) && (ring_q == T4 || ring_q == T5 || ring_q == T6);
      case (ring_q)
        T1: begin
          ep = 1'b1;
          lm = 1'b1;
        end
        T2: cp = 1'b1;
        T3: begin
          ce = 1'b1;
          li = 1'b1;
        end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              ei = 1'b1;
              lm = 1'b1;
            end
            OP_OUT: begin
              ea = 1'b1;
              lo = 1'b1;
            end
            OP_HLT:  hlt = halt_now;
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin
              ce = 1'b1;
              la = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ce = 1'b1;
              lb = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            eu = 1'b1;
            la = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
